// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: handshake bundle between the immediate generator and its
// neighbours.
//   master : the side that presents immediates and takes results
//            (in_valid, in_imm, in_mode, flush, out_ready).
//   slave  : the immediate generator itself
//            (in_ready, out_valid, out_imm).
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;

  modport master (
    output in_valid, in_imm, in_mode, flush, out_ready,
    input  in_ready, out_valid, out_imm
  );

  modport slave (
    input  in_valid, in_imm, in_mode, flush, out_ready,
    output in_ready, out_valid, out_imm
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate generator for the ID/EX boundary.
// The IN_W-bit immediate is extended to OUT_W bits combinationally on the
// input side, then carried through STAGES {valid, data} registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imm_ext_pipe_if.slave
//                in_valid/in_ready/in_imm/in_mode  input handshake
//                out_valid/out_ready/out_imm       output handshake
//                flush                             kills all in-flight entries
// in_mode: 00 sign-extend, 01 zero-extend, 10 upper (LUI), 11 branch offset.
// Build option: define IMM_EXT_BRANCH_EN to build the branch-offset shifter;
// without it mode 11 is an ordinary sign-extend.
module imm_ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_pipe_if.slave bus
);

  localparam int PAD_W = OUT_W - IN_W;

  // ---------------------------------------------------------------------------
  // Extension (input side, combinational)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] ext_sign, ext_zero, ext_upper, ext_imm;

  assign ext_sign  = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
  assign ext_zero  = {{PAD_W{1'b0}}, bus.in_imm};
  // The shift amount is OUT_W-IN_W, so the immediate lands exactly in the
  // top IN_W bits.
  assign ext_upper = {bus.in_imm, {PAD_W{1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
  logic [OUT_W-1:0] ext_branch;
  // Word offset -> byte offset; the top two sign bits fall off.
  assign ext_branch = {ext_sign[OUT_W-3:0], 2'b00};
`endif

  always_comb begin
    ext_imm = ext_sign;
    case (bus.in_mode)
      2'b01:   ext_imm = ext_zero;
      2'b10:   ext_imm = ext_upper;
`ifdef IMM_EXT_BRANCH_EN
      2'b11:   ext_imm = ext_branch;
`else
      2'b11:   ext_imm = ext_sign;
`endif
      default: ext_imm = ext_sign;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0]            vld_pipe_d, vld_pipe_q;
  logic [STAGES-1:0][OUT_W-1:0] data_d, data_q;
  logic                         en, accept;

  // Whole pipe advances unless the last stage holds an unaccepted result;
  // bubbles inside the pipe are deliberately not squeezed out.
  assign en           = bus.out_ready | ~vld_pipe_q[STAGES-1];
  assign bus.in_ready = en & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage 0. accept already implies en and ~flush.
  assign vld_pipe_d[0] = bus.flush ? 1'b0 : (en ? accept : vld_pipe_q[0]);
  assign data_d[0]     = accept ? ext_imm : data_q[0];

  // Data only moves behind a valid bit, so bubbles and flushes leave the
  // data registers untouched.
  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    assign vld_pipe_d[s] = bus.flush ? 1'b0 :
                           (en ? vld_pipe_q[s-1] : vld_pipe_q[s]);
    assign data_d[s]     = (en & ~bus.flush & vld_pipe_q[s-1]) ?
                           data_q[s-1] : data_q[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      data_q     <= data_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES-1];
  assign bus.out_imm   = data_q[STAGES-1];

endmodule
